// File: rtl/sram_ctrl_if.sv
// Host-side bus of sram_ctrl: access request with address/data, and the completion handshake.
interface sram_ctrl_if;
  logic        req;
  logic        rw;
  logic [19:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        ready;
  logic        busy;

  modport master (output req, rw, addr, wdata, input rdata, ready, busy);
  modport slave  (input req, rw, addr, wdata, output rdata, ready, busy);
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: one access at a time on a 1M x 8 async SRAM; ready RD_WAIT (read) or WR_WAIT+2 (write) cycles after acceptance.
// req while busy is dropped, never queued; define SRAM_CTRL_DROP_CNT_EN to add a saturating drop_cnt_o.
module sram_ctrl #(
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned WR_WAIT = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  sram_ctrl_if.slave  bus,
  output logic [19:0] sram_addr_o,
  inout  wire  [7:0]  sram_dq_io,
  output logic        sram_ce_n_o,
  output logic        sram_oe_n_o,
  output logic        sram_we_n_o
`ifdef SRAM_CTRL_DROP_CNT_EN
  ,
  output logic [7:0]  drop_cnt_o
`endif
);

  typedef enum logic [2:0] {IDLE, RD, WSU, WPL, WHD} state_t;

  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [19:0] addr_q;
  logic [7:0]  wdat_q;
  logic [7:0]  rdata_q;
  logic        dq_oe_q;
  logic        ce_n_q;
  logic        oe_n_q;
  logic        we_n_q;
  logic        ready_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdata_q <= '0;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req) begin
            addr_q <= bus.addr;
            wdat_q <= bus.wdata;
            ce_n_q <= 1'b0;
            if (bus.rw) begin
              oe_n_q  <= 1'b0;
              cnt_q   <= RD_LOAD;
              state_q <= RD;
            end else begin
              dq_oe_q <= 1'b1;
              state_q <= WSU;
            end
          end
        end
        RD: begin
          if (cnt_q == 4'd0) begin
            rdata_q <= sram_dq_io;
            ready_q <= 1'b1;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        WSU: begin
          we_n_q  <= 1'b0;
          cnt_q   <= WR_LOAD;
          state_q <= WPL;
        end
        WPL: begin
          if (cnt_q == 4'd0) begin
            we_n_q  <= 1'b1;
            state_q <= WHD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        WHD: begin
          // Address and data stay on the pins through this cycle for SRAM hold time.
          ready_q <= 1'b1;
          ce_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SRAM_CTRL_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      if (bus.req) drop_cnt_q <= '0;
    end else if (bus.req && drop_cnt_q != 8'hFF) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

  assign bus.rdata   = rdata_q;
  assign bus.ready   = ready_q;
  assign bus.busy    = (state_q != IDLE);
  assign sram_addr_o = addr_q;
  assign sram_ce_n_o = ce_n_q;
  assign sram_oe_n_o = oe_n_q;
  assign sram_we_n_o = we_n_q;
  assign sram_dq_io  = dq_oe_q ? wdat_q : 8'bz;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: table of accesses against a behavioural SRAM with a ready-driven scoreboard,
// plus back-to-back, reset-abort, busy-drop and RD_WAIT=1/15 latency sequences.
`timescale 1ns/1ps
module tb_sram_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_ctrl_if bus();
  sram_ctrl_if bus1();
  sram_ctrl_if bus15();

  logic [19:0] sram_addr, addr1, addr15;
  wire  [7:0]  sram_dq, dq1, dq15;
  logic        ce_n, oe_n, we_n;
  logic        ce1, oe1, we1;
  logic        ce15, oe15, we15;
`ifdef SRAM_CTRL_DROP_CNT_EN
  logic [7:0]  drop_cnt, drop1, drop15;
`endif

  sram_ctrl #(.RD_WAIT(2), .WR_WAIT(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus),
    .sram_addr_o(sram_addr), .sram_dq_io(sram_dq),
    .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n), .sram_we_n_o(we_n)
`ifdef SRAM_CTRL_DROP_CNT_EN
    , .drop_cnt_o(drop_cnt)
`endif
  );

  sram_ctrl #(.RD_WAIT(1), .WR_WAIT(2)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus1),
    .sram_addr_o(addr1), .sram_dq_io(dq1),
    .sram_ce_n_o(ce1), .sram_oe_n_o(oe1), .sram_we_n_o(we1)
`ifdef SRAM_CTRL_DROP_CNT_EN
    , .drop_cnt_o(drop1)
`endif
  );

  sram_ctrl #(.RD_WAIT(15), .WR_WAIT(2)) dut15 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus15),
    .sram_addr_o(addr15), .sram_dq_io(dq15),
    .sram_ce_n_o(ce15), .sram_oe_n_o(oe15), .sram_we_n_o(we15)
`ifdef SRAM_CTRL_DROP_CNT_EN
    , .drop_cnt_o(drop15)
`endif
  );

  // Main SRAM model, aliased on addr[11:0]; the test addresses are chosen distinct there.
  logic [7:0] mem [0:4095];
  logic [7:0] mem_rd;
  always_comb mem_rd = mem[sram_addr[11:0]];
  assign sram_dq = (!ce_n && !oe_n) ? mem_rd : 8'bz;
  always @(posedge we_n) if (!ce_n) mem[sram_addr[11:0]] = sram_dq;

  assign dq1  = (!ce1  && !oe1)  ? (addr1[7:0]  ^ 8'h3C) : 8'bz;
  assign dq15 = (!ce15 && !oe15) ? (addr15[7:0] ^ 8'h3C) : 8'bz;

  typedef struct packed { logic is_rd; logic [7:0] exp; } sb_t;
  sb_t        sb_q[$];
  sb_t        mon_e;
  int         total = 0;
  int         bad   = 0;
  logic [7:0] last_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.ready) begin
      if (sb_q.size() == 0) begin
        chk("ready with empty scoreboard", 32'(sb_q.size()), 32'd1);
      end else begin
        mon_e = sb_q.pop_front();
        chk(mon_e.is_rd ? "read data" : "rdata held over write", {24'd0, bus.rdata}, {24'd0, mon_e.exp});
      end
    end
  end

  // Drives one access from a negedge; returns on the negedge where ready is seen.
  task automatic run_access(input logic rw, input logic [19:0] a, input logic [7:0] wd,
                            input logic [7:0] exp_rd, input int exp_lat, input bit keep_req);
    int lat = -1;
    int ce_lo = 0, oe_lo = 0, we_lo = 0, dq_bad = 0, addr_bad = 0, busy_bad = 0;
    bus.req = 1'b1; bus.rw = rw; bus.addr = a; bus.wdata = wd;
    sb_q.push_back(rw ? sb_t'{1'b1, exp_rd} : sb_t'{1'b0, last_rd});
    if (rw) last_rd = exp_rd;
    @(posedge clk);
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (keep_req) begin
          bus.rw = ~rw; bus.wdata = ~wd;
        end else begin
          bus.req = 1'b0;
        end
      end
      if (bus.ready) begin
        lat = i;
      end else begin
        if (!bus.busy) busy_bad++;
        if (sram_addr !== a) addr_bad++;
        if (!ce_n) ce_lo++;
        if (!oe_n) oe_lo++;
        if (!we_n) we_lo++;
        if (!rw && sram_dq !== wd) dq_bad++;
      end
    end
    chk(rw ? "read latency" : "write latency", lat, exp_lat);
    chk("busy low in ready cycle", {31'd0, bus.busy}, 32'd0);
    chk("busy during access", busy_bad, 0);
    chk("sram_addr during access", addr_bad, 0);
    chk("ce_n low cycles", ce_lo, exp_lat);
    chk(rw ? "oe_n low cycles" : "oe_n low during write", oe_lo, rw ? 2 : 0);
    chk("we_n low cycles", we_lo, rw ? 0 : 2);
    if (!rw) begin
      chk("dq driven with write data", dq_bad, 0);
      chk("SRAM contents after write", {24'd0, mem[a[11:0]]}, {24'd0, wd});
    end
  endtask

  typedef struct { logic rw; logic [19:0] addr; logic [7:0] wdata; logic [7:0] rdata; int lat; } vec_t;
  vec_t vecs[8];

  initial begin
    int lat;
    int rdy;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h123] = 8'h5A;
    vecs[0] = '{1'b1, 20'h0B123, 8'h00, 8'h5A, 2};
    vecs[1] = '{1'b0, 20'hFF00E, 8'hC3, 8'h00, 4};
    vecs[2] = '{1'b1, 20'hFF00E, 8'h00, 8'hC3, 2};
    vecs[3] = '{1'b0, 20'h00777, 8'hA5, 8'h00, 4};
    vecs[4] = '{1'b0, 20'h00778, 8'h96, 8'h00, 4};
    vecs[5] = '{1'b1, 20'h00777, 8'h00, 8'hA5, 2};
    vecs[6] = '{1'b1, 20'h00778, 8'h00, 8'h96, 2};
    vecs[7] = '{1'b1, 20'h0B123, 8'h00, 8'h5A, 2};

    bus.req = 0;   bus.rw = 0;   bus.addr = '0;   bus.wdata = '0;
    bus1.req = 0;  bus1.rw = 0;  bus1.addr = '0;  bus1.wdata = '0;
    bus15.req = 0; bus15.rw = 0; bus15.addr = '0; bus15.wdata = '0;
    last_rd = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset ce_n", {31'd0, ce_n}, 32'd1);
    chk("reset oe_n", {31'd0, oe_n}, 32'd1);
    chk("reset we_n", {31'd0, we_n}, 32'd1);
    chk("reset sram_addr", {12'd0, sram_addr}, 32'd0);
    chk("reset rdata", {24'd0, bus.rdata}, 32'd0);
    chk("reset ready", {31'd0, bus.ready}, 32'd0);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++)
      run_access(vecs[v].rw, vecs[v].addr, vecs[v].wdata, vecs[v].rdata, vecs[v].lat, 1'b0);

    // Back-to-back: req held through the write's ready cycle, read accepted on that cycle's edge.
    run_access(1'b0, 20'h00010, 8'h11, 8'h00, 4, 1'b1);
    run_access(1'b1, 20'h00010, 8'h00, 8'h11, 2, 1'b0);
    @(negedge clk);

    // Reset asserted during the write pulse.
    bus.req = 1'b1; bus.rw = 1'b0; bus.addr = 20'h00200; bus.wdata = 8'h77;
    sb_q.push_back(sb_t'{1'b0, last_rd});
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    chk("we_n low before reset", {31'd0, we_n}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("we_n on mid-write reset", {31'd0, we_n}, 32'd1);
    chk("ce_n on mid-write reset", {31'd0, ce_n}, 32'd1);
    chk("oe_n on mid-write reset", {31'd0, oe_n}, 32'd1);
    chk("busy on mid-write reset", {31'd0, bus.busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("no ready for abandoned write", 32'(sb_q.size()), 32'd1);
    sb_q.delete();
    last_rd = 8'h00;
    chk("rdata after reset", {24'd0, bus.rdata}, 32'd0);
    run_access(1'b1, 20'h0B123, 8'h00, 8'h5A, 2, 1'b0);

    // RD_WAIT=1 build.
    bus1.req = 1'b1; bus1.rw = 1'b1; bus1.addr = 20'h00042;
    @(posedge clk);
    lat = -1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      if (i == 0) bus1.req = 1'b0;
      if (bus1.ready) lat = i;
    end
    chk("RD_WAIT=1 latency", lat, 1);
    chk("RD_WAIT=1 rdata", {24'd0, bus1.rdata}, 32'h7E);

    // RD_WAIT=15 build, with three dropped req pulses and an address change while busy.
    bus15.req = 1'b1; bus15.rw = 1'b1; bus15.addr = 20'h12345;
    @(posedge clk);
    lat = -1;
    rdy = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      bus15.req = (i == 2 || i == 5 || i == 8);
      if (i == 1) bus15.addr = 20'h00000;
      if (bus15.ready) begin
        rdy++;
        if (lat < 0) lat = i;
      end
    end
    chk("RD_WAIT=15 latency", lat, 15);
    chk("RD_WAIT=15 rdata", {24'd0, bus15.rdata}, 32'h79);
    chk("one ready despite dropped reqs", rdy, 1);
`ifdef SRAM_CTRL_DROP_CNT_EN
    chk("drop_cnt after 3 drops", {24'd0, drop15}, 32'd3);
    chk("drop_cnt idle instance", {24'd0, drop1}, 32'd0);
`endif
    bus15.req = 1'b1; bus15.rw = 1'b1; bus15.addr = 20'h00001;
    @(posedge clk);
    @(negedge clk);
    bus15.req = 1'b0;
    chk("RD_WAIT=15 accepts after drops", {31'd0, bus15.busy}, 32'd1);
`ifdef SRAM_CTRL_DROP_CNT_EN
    chk("drop_cnt cleared on accept", {24'd0, drop15}, 32'd0);
`endif
    repeat (20) @(negedge clk);
    chk("RD_WAIT=15 second read data", {24'd0, bus15.rdata}, 32'h3D);
    chk("read-only instances never write", {30'd0, we1, we15}, 32'd3);
    chk("RD_WAIT=1 idle at end", {31'd0, bus1.busy}, 32'd0);
    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
